// File: rtl/time_display.sv
// Seven-segment scan driver for the 17-bit h/m/s time bus: 24 h or 12 h presentation,
// per-field edit blinking, and one time snapshot per refresh frame.
module time_display #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] current_time,
    input  logic        fmt_12h,
    input  logic [1:0]  blink,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam int unsigned DIGIT_CYCLES = CLK_FREQ / (REFRESH_HZ * 8);
    localparam int unsigned BLINK_CYCLES = CLK_FREQ / 4;
    localparam int unsigned PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIGIT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [16:0]   snap_time_q, snap_time_d;
    logic          snap_fmt_q, snap_fmt_d;
    logic [7:0]    anodes_d;
    logic [6:0]    segments_d;
    logic          dp_d;

    logic          frame_start;
    logic [4:0]    hr, hr_disp;
    logic [5:0]    mn, sc;
    logic          hr_ok, mn_ok, sc_ok;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] ones(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    // The frame's first digit must already show the value being captured this cycle.
    assign frame_start = (presc_q == '0) && (digit_idx_q == 3'd0);

    always_comb begin
        presc_d       = presc_q;
        digit_idx_d   = digit_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_time_d   = snap_time_q;
        snap_fmt_d    = snap_fmt_q;
        if (presc_q == PRESC_MAX) begin
            presc_d     = '0;
            digit_idx_d = digit_idx_q + 3'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
        if (frame_start) begin
            snap_time_d = current_time;
            snap_fmt_d  = fmt_12h;
        end
    end

    assign hr    = snap_time_d[16:12];
    assign mn    = snap_time_d[11:6];
    assign sc    = snap_time_d[5:0];
    assign hr_ok = (hr <= 5'd23);
    assign mn_ok = (mn <= 6'd59);
    assign sc_ok = (sc <= 6'd59);

    always_comb begin
        hr_disp = hr;
        if (snap_fmt_d) begin
            if (hr == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr > 5'd12) begin
                hr_disp = hr - 5'd12;
            end
        end
    end

    always_comb begin
        anodes_d   = ~(8'd1 << digit_idx_q);
        segments_d = SEG_BLANK;
        dp_d       = 1'b1;
        case (digit_idx_q)
            3'd0: segments_d = sc_ok ? seg_digit(ones(sc)) : SEG_DASH;
            3'd1: segments_d = sc_ok ? seg_digit(tens(sc)) : SEG_DASH;
            3'd2: begin
                segments_d = mn_ok ? seg_digit(ones(mn)) : SEG_DASH;
                dp_d       = 1'b0;
            end
            3'd3: segments_d = mn_ok ? seg_digit(tens(mn)) : SEG_DASH;
            3'd4: begin
                segments_d = hr_ok ? seg_digit(ones({1'b0, hr_disp})) : SEG_DASH;
                dp_d       = 1'b0;
            end
            3'd5: segments_d = hr_ok ? seg_digit(tens({1'b0, hr_disp})) : SEG_DASH;
            3'd6: begin
                if (snap_fmt_d && hr_ok) begin
                    segments_d = (hr >= 5'd12) ? SEG_P : SEG_A;
                end
            end
            default: segments_d = SEG_BLANK;
        endcase
        if (blink_phase_q) begin
            if (blink[1] && (digit_idx_q >= 3'd4) && (digit_idx_q <= 3'd6)) begin
                segments_d = SEG_BLANK;
                dp_d       = 1'b1;
            end
            if (blink[0] && ((digit_idx_q == 3'd2) || (digit_idx_q == 3'd3))) begin
                segments_d = SEG_BLANK;
                dp_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            digit_idx_q   <= 3'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_time_q   <= 17'd0;
            snap_fmt_q    <= 1'b0;
            anodes        <= 8'hFF;
            segments      <= 7'h7F;
            dp            <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_time_q   <= snap_time_d;
            snap_fmt_q    <= snap_fmt_d;
            anodes        <= anodes_d;
            segments      <= segments_d;
            dp            <= dp_d;
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: directed scenarios plus randomized traffic, every output cycle
// compared with a cycle-indexed reference model built from the input history.
module tb_time_display;

    localparam int unsigned CLK_FREQ   = 800;
    localparam int unsigned REFRESH_HZ = 10;
    localparam int DC    = 10;
    localparam int FRAME = 80;
    localparam int HALF  = 200;
    localparam int HMAX  = 1024;

    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_P     = 7'b0001100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] current_time = 17'd0;
    logic        fmt_12h = 1'b0;
    logic [1:0]  blink = 2'b00;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [16:0] h_time  [HMAX];
    logic        h_fmt   [HMAX];
    logic [1:0]  h_blink [HMAX];

    time_display #(
        .CLK_FREQ   (CLK_FREQ),
        .REFRESH_HZ (REFRESH_HZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time),
        .fmt_12h      (fmt_12h),
        .blink        (blink),
        .anodes       (anodes),
        .segments     (segments),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dseg(input int v);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[v];
    endfunction

    // Expected {anodes, segments, dp} at output cycle n (n >= 1 since reset release).
    function automatic logic [15:0] model(input int n);
        int m, d, f, hr, mn, sc, hd;
        logic [16:0] t;
        logic fm, ph;
        logic [1:0] bl;
        logic [6:0] sg;
        logic dpe;
        m  = n - 1;
        d  = (m / DC) % 8;
        f  = m - (m % FRAME);
        t  = h_time[f];
        fm = h_fmt[f];
        bl = h_blink[m];
        ph = ((m / HALF) % 2) == 1;
        hr = int'(t[16:12]);
        mn = int'(t[11:6]);
        sc = int'(t[5:0]);
        hd = hr;
        if (fm) hd = (hr == 0) ? 12 : ((hr > 12) ? hr - 12 : hr);
        sg  = S_BLANK;
        dpe = !(d == 2 || d == 4);
        case (d)
            0: sg = (sc < 60) ? dseg(sc % 10) : S_DASH;
            1: sg = (sc < 60) ? dseg(sc / 10) : S_DASH;
            2: sg = (mn < 60) ? dseg(mn % 10) : S_DASH;
            3: sg = (mn < 60) ? dseg(mn / 10) : S_DASH;
            4: sg = (hr < 24) ? dseg(hd % 10) : S_DASH;
            5: sg = (hr < 24) ? dseg(hd / 10) : S_DASH;
            6: sg = (fm && hr < 24) ? ((hr >= 12) ? S_P : S_A) : S_BLANK;
            default: sg = S_BLANK;
        endcase
        if (ph && ((bl[1] && d >= 4 && d <= 6) || (bl[0] && (d == 2 || d == 3)))) begin
            sg  = S_BLANK;
            dpe = 1'b1;
        end
        return {~(8'd1 << d), sg, dpe};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed an/seg/dp=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic dchk(input string tag, input logic [7:0] an, input logic [6:0] sg,
                        input logic d);
        check(tag, {anodes, segments, dp}, {an, sg, d});
    endtask

    task automatic tick();
        if (cyc < HMAX) begin
            h_time[cyc]  = current_time;
            h_fmt[cyc]   = fmt_12h;
            h_blink[cyc] = blink;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < HMAX) check("model", {anodes, segments, dp}, model(cyc));
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start(input logic [16:0] t, input logic f, input logic [1:0] b);
        current_time = t;
        fmt_12h      = f;
        blink        = b;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        dchk("reset", 8'hFF, 7'h7F, 1'b1);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;

        // 24 h basic scan, mid-frame time change
        start({5'd13, 6'd45, 6'd7}, 1'b0, 2'b00);
        run_to(1);   dchk("d0_7", 8'hFE, dseg(7), 1'b1);
        run_to(11);  dchk("d1_0", 8'hFD, dseg(0), 1'b1);
        run_to(21);  dchk("d2_5_dp", 8'hFB, dseg(5), 1'b0);
        run_to(31);  dchk("d3_4", 8'hF7, dseg(4), 1'b1);
        run_to(35);  current_time = {5'd2, 6'd31, 6'd58};
        run_to(41);  dchk("d4_old3", 8'hEF, dseg(3), 1'b0);
        run_to(51);  dchk("d5_old1", 8'hDF, dseg(1), 1'b1);
        run_to(61);  dchk("d6_blank24", 8'hBF, S_BLANK, 1'b1);
        run_to(71);  dchk("d7_blank", 8'h7F, S_BLANK, 1'b1);
        run_to(81);  dchk("new_d0_8", 8'hFE, dseg(8), 1'b1);
        run_to(121); dchk("new_d4_2", 8'hEF, dseg(2), 1'b0);
        run_to(160);

        // 12 h mapping: 13 -> 1 PM, 0 -> 12 AM, 12 -> 12 PM
        start({5'd13, 6'd45, 6'd7}, 1'b1, 2'b00);
        run_to(41);  dchk("h13_ones", 8'hEF, dseg(1), 1'b0);
        run_to(51);  dchk("h13_tens", 8'hDF, dseg(0), 1'b1);
        run_to(61);  dchk("h13_pm", 8'hBF, S_P, 1'b1);
        run_to(75);  current_time = {5'd0, 6'd45, 6'd7};
        run_to(121); dchk("h0_ones", 8'hEF, dseg(2), 1'b0);
        run_to(131); dchk("h0_tens", 8'hDF, dseg(1), 1'b1);
        run_to(141); dchk("h0_am", 8'hBF, S_A, 1'b1);
        run_to(150); current_time = {5'd12, 6'd0, 6'd0};
        run_to(201); dchk("h12_ones", 8'hEF, dseg(2), 1'b0);
        run_to(211); dchk("h12_tens", 8'hDF, dseg(1), 1'b1);
        run_to(221); dchk("h12_pm", 8'hBF, S_P, 1'b1);

        // Invalid fields
        start({5'd24, 6'd60, 6'd59}, 1'b1, 2'b00);
        run_to(1);   dchk("inv_s9", 8'hFE, dseg(9), 1'b1);
        run_to(11);  dchk("inv_s5", 8'hFD, dseg(5), 1'b1);
        run_to(21);  dchk("inv_m_dash", 8'hFB, S_DASH, 1'b0);
        run_to(31);  dchk("inv_m_dash2", 8'hF7, S_DASH, 1'b1);
        run_to(41);  dchk("inv_h_dash", 8'hEF, S_DASH, 1'b0);
        run_to(51);  dchk("inv_h_dash2", 8'hDF, S_DASH, 1'b1);
        run_to(61);  dchk("inv_ampm_blank", 8'hBF, S_BLANK, 1'b1);
        run_to(80);

        // Blink hours, then minutes
        start({5'd13, 6'd45, 6'd7}, 1'b0, 2'b10);
        run_to(41);  dchk("bh_before", 8'hEF, dseg(3), 1'b0);
        run_to(201); dchk("bh_d4", 8'hEF, S_BLANK, 1'b1);
        run_to(211); dchk("bh_d5", 8'hDF, S_BLANK, 1'b1);
        run_to(221); dchk("bh_d6", 8'hBF, S_BLANK, 1'b1);
        run_to(241); dchk("bh_sec", 8'hFE, dseg(7), 1'b1);
        run_to(261); dchk("bh_min", 8'hFB, dseg(5), 1'b0);
        run_to(361); dchk("bh_d4_late", 8'hEF, S_BLANK, 1'b1);
        run_to(441); dchk("bh_after", 8'hEF, dseg(3), 1'b0);
        run_to(450); blink = 2'b01;
        run_to(661); dchk("bm_d2", 8'hFB, S_BLANK, 1'b1);
        run_to(681); dchk("bm_hours", 8'hEF, dseg(3), 1'b0);
        run_to(700);

        // Reset asserted mid-frame
        start({5'd13, 6'd45, 6'd7}, 1'b0, 2'b00);
        run_to(57);
        reset = 1'b1;
        @(posedge clk);
        #1;
        dchk("midreset", 8'hFF, 7'h7F, 1'b1);
        reset = 1'b0;
        cyc   = 0;
        tick();
        dchk("restart_d0", 8'hFE, dseg(7), 1'b1);
        run_to(100);

        // Randomized traffic against the model
        start({5'd9, 6'd30, 6'd15}, 1'b0, 2'b00);
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 25) == 0)
                current_time = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                                6'($urandom_range(0, 63))};
            if ($urandom_range(0, 60) == 0) fmt_12h = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 90) == 0) blink = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
